// File: rtl/key_dir_sched.sv
// key_dir_sched: direction/step scheduler between the PS/2 key decoder and
// the game core.
//
// Consumes held-level key flags. Arbitrates simultaneous presses so the most
// recently pressed key wins. Runs the IDLE/RUN/PAUSE/OVER game-state FSM from
// Enter. Issues paced movement steps over a req/ack handshake.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   up/down/left/right    held-level direction key flags
//   enter                 held-level Enter flag
//   game_over             level from game core; forces OVER from RUN/PAUSE
//   step_ack              game core accepted the pending step
//   dir, dir_valid        arbitrated direction (0 up,1 down,2 left,3 right), any key held
//   step_req, step_dir    step request (held until acked) and its direction
//   step_miss             one-cycle pulse when a step coalesces into a pending request
//   state                 0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
//   start_pulse           one-cycle pulse on IDLE->RUN
module key_dir_sched #(
  parameter int unsigned STEP_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       enter,
  input  logic       game_over,
  input  logic       step_ack,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       step_req,
  output logic [1:0] step_dir,
  output logic       step_miss,
  output logic [1:0] state,
  output logic       start_pulse
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StOver  = 2'd3
  } state_e;

  localparam int unsigned CntW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_DIV - 1);

  // Key vector indexed by direction code, so bit i encodes dir == i and a
  // lowest-index scan gives the up > down > left > right priority.
  logic [3:0]      keys;
  logic [3:0]      key_rise;
  logic            enter_rise;
  logic [1:0]      rise_pick;
  logic [1:0]      held_pick;
  logic            run_stay;
  logic            step_evt;

  logic [3:0]      key_hist_q;
  logic            enter_hist_q;
  logic [1:0]      dir_q, dir_d;
  logic            dir_valid_q, dir_valid_d;
  logic            step_req_q, step_req_d;
  logic [1:0]      step_dir_q, step_dir_d;
  logic            step_miss_q, step_miss_d;
  state_e          state_q, state_d;
  logic            start_pulse_q, start_pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Edge detection. History resets to 0, so a key held through reset release
  // is seen as a rise on the first sampled cycle.
  always_comb begin
    keys       = {right, left, down, up};
    key_rise   = keys & ~key_hist_q;
    enter_rise = enter & ~enter_hist_q;
  end

  // Arbitration: a rise always takes over; if the current key is released,
  // fall back to the highest-priority key still held; with nothing held,
  // dir keeps its last value.
  always_comb begin
    rise_pick = 2'd0;
    held_pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (key_rise[i]) rise_pick = 2'(i);
      if (keys[i])     held_pick = 2'(i);
    end

    dir_d       = dir_q;
    dir_valid_d = |keys;
    if (|key_rise) begin
      dir_d = rise_pick;
    end else if ((|keys) && !keys[dir_q]) begin
      dir_d = held_pick;
    end
  end

  // Game-state FSM. game_over outranks an Enter rise in RUN/PAUSE.
  always_comb begin
    state_d       = state_q;
    start_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enter_rise) begin
          state_d       = StRun;
          start_pulse_d = 1'b1;
        end
      end
      StRun: begin
        if (game_over)       state_d = StOver;
        else if (enter_rise) state_d = StPause;
      end
      StPause: begin
        if (game_over)       state_d = StOver;
        else if (enter_rise) state_d = StRun;
      end
      StOver: begin
        if (enter_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Step pacing. Events only while RUN persists across this edge; any state
  // change clears the counter, so PAUSE->RUN restarts counting from 0 with no
  // immediate step.
  always_comb begin
    run_stay = (state_q == StRun) && (state_d == StRun);
    step_evt = 1'b0;
    cnt_d    = '0;
    if (run_stay && dir_valid_d) begin
      if (|key_rise) begin
        step_evt = 1'b1;
      end else if (cnt_q == CntLast) begin
        step_evt = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Handshake. A new event always (re)asserts the request with the latest
  // direction; it only counts as a miss if the old one was not acked now.
  always_comb begin
    step_req_d  = step_req_q;
    step_dir_d  = step_dir_q;
    step_miss_d = 1'b0;
    if (step_evt) begin
      step_req_d  = 1'b1;
      step_dir_d  = dir_d;
      step_miss_d = step_req_q & ~step_ack;
    end else if (step_req_q && step_ack) begin
      step_req_d = 1'b0;
    end
    // A pending request outlives PAUSE/OVER but not a return to IDLE.
    if ((state_q == StOver) && (state_d == StIdle)) begin
      step_req_d  = 1'b0;
      step_miss_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_hist_q    <= '0;
      enter_hist_q  <= 1'b0;
      dir_q         <= 2'd0;
      dir_valid_q   <= 1'b0;
      step_req_q    <= 1'b0;
      step_dir_q    <= 2'd0;
      step_miss_q   <= 1'b0;
      state_q       <= StIdle;
      start_pulse_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      key_hist_q    <= keys;
      enter_hist_q  <= enter;
      dir_q         <= dir_d;
      dir_valid_q   <= dir_valid_d;
      step_req_q    <= step_req_d;
      step_dir_q    <= step_dir_d;
      step_miss_q   <= step_miss_d;
      state_q       <= state_d;
      start_pulse_q <= start_pulse_d;
      cnt_q         <= cnt_d;
    end
  end

  assign dir         = dir_q;
  assign dir_valid   = dir_valid_q;
  assign step_req    = step_req_q;
  assign step_dir    = step_dir_q;
  assign step_miss   = step_miss_q;
  assign state       = state_q;
  assign start_pulse = start_pulse_q;

endmodule

// File: tb/tb_key_dir_sched.sv
// Directed self-checking bench for key_dir_sched with STEP_DIV = 8.
// step_ack follows step_req combinationally (request acked at the first edge
// after it rises) unless auto_ack is cleared, in which case manual_ack drives it.
module tb_key_dir_sched;

  localparam int unsigned StepDiv = 8;

  logic       clk;
  logic       rst;
  logic       up, down, left, right, enter, game_over;
  logic       step_ack;
  logic       auto_ack, manual_ack;
  logic [1:0] dir;
  logic       dir_valid;
  logic       step_req;
  logic [1:0] step_dir;
  logic       step_miss;
  logic [1:0] state;
  logic       start_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  assign step_ack = auto_ack ? step_req : manual_ack;

  key_dir_sched #(
    .STEP_DIV(StepDiv)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .enter      (enter),
    .game_over  (game_over),
    .step_ack   (step_ack),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .step_req   (step_req),
    .step_dir   (step_dir),
    .step_miss  (step_miss),
    .state      (state),
    .start_pulse(start_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int extra;
    rst        = 1'b1;
    up         = 1'b0;
    down       = 1'b0;
    left       = 1'b0;
    right      = 1'b0;
    enter      = 1'b0;
    game_over  = 1'b0;
    auto_ack   = 1'b1;
    manual_ack = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_dir", 32'(dir), 0);
    check_eq("rst_dir_valid", 32'(dir_valid), 0);
    check_eq("rst_step_req", 32'(step_req), 0);
    check_eq("rst_step_dir", 32'(step_dir), 0);
    check_eq("rst_step_miss", 32'(step_miss), 0);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_start_pulse", 32'(start_pulse), 0);
    rst = 1'b0;
    tick();

    // Enter sequencing: IDLE->RUN->PAUSE->RUN
    enter = 1'b1;
    tick();
    check_eq("enter1_state", 32'(state), 1);
    check_eq("enter1_start", 32'(start_pulse), 1);
    tick();
    check_eq("enter1_state_hold", 32'(state), 1);
    check_eq("enter1_start_once", 32'(start_pulse), 0);
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    check_eq("enter2_state", 32'(state), 2);
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    check_eq("enter3_state", 32'(state), 1);
    check_eq("enter3_no_start", 32'(start_pulse), 0);
    enter = 1'b0;
    tick();

    // Hold right: step on press, then every 8 cycles
    right = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_eq($sformatf("right_req_c%0d", c), 32'(step_req), ((c % 8) == 0) ? 1 : 0);
      if (c == 0) begin
        check_eq("right_step_dir", 32'(step_dir), 3);
        check_eq("right_dir", 32'(dir), 3);
        check_eq("right_dir_valid", 32'(dir_valid), 1);
      end
    end
    right = 1'b0;
    tick();
    check_eq("rel_dir_valid", 32'(dir_valid), 0);
    check_eq("rel_dir_kept", 32'(dir), 3);
    extra = 0;
    repeat (10) begin
      tick();
      if (step_req) extra++;
    end
    check_eq("rel_no_steps", 32'(extra), 0);

    // Latest-pressed-wins arbitration
    up = 1'b1;
    tick();
    check_eq("up_dir", 32'(dir), 0);
    check_eq("up_req", 32'(step_req), 1);
    tick();
    check_eq("up_acked", 32'(step_req), 0);
    left = 1'b1;
    tick();
    check_eq("left_over_up_dir", 32'(dir), 2);
    check_eq("left_step_req", 32'(step_req), 1);
    check_eq("left_step_dir", 32'(step_dir), 2);
    left = 1'b0;
    tick();
    check_eq("left_rel_fallback", 32'(dir), 0);
    check_eq("left_rel_valid", 32'(dir_valid), 1);
    down  = 1'b1;
    right = 1'b1;
    tick();
    check_eq("down_right_prio", 32'(dir), 1);
    check_eq("down_right_step_dir", 32'(step_dir), 1);
    up    = 1'b0;
    down  = 1'b0;
    right = 1'b0;
    tick();
    tick();
    check_eq("idle_keys_req", 32'(step_req), 0);

    // Coalescing with ack held low
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    up = 1'b1;
    tick();
    check_eq("coal1_req", 32'(step_req), 1);
    check_eq("coal1_dir", 32'(step_dir), 0);
    check_eq("coal1_miss", 32'(step_miss), 0);
    left = 1'b1;
    tick();
    check_eq("coal2_req", 32'(step_req), 1);
    check_eq("coal2_dir", 32'(step_dir), 2);
    check_eq("coal2_miss", 32'(step_miss), 1);
    tick();
    check_eq("coal2_miss_once", 32'(step_miss), 0);
    check_eq("coal2_req_hold", 32'(step_req), 1);
    down       = 1'b1;
    manual_ack = 1'b1;
    tick();
    check_eq("coal3_req", 32'(step_req), 1);
    check_eq("coal3_dir", 32'(step_dir), 1);
    check_eq("coal3_no_miss", 32'(step_miss), 0);
    manual_ack = 1'b0;
    up   = 1'b0;
    left = 1'b0;
    down = 1'b0;
    tick();
    check_eq("pending_req", 32'(step_req), 1);

    // game_over beats Enter; pending request survives into OVER
    game_over = 1'b1;
    enter     = 1'b1;
    tick();
    check_eq("over_state", 32'(state), 3);
    check_eq("over_req_kept", 32'(step_req), 1);
    game_over = 1'b0;
    enter     = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    check_eq("over_to_idle", 32'(state), 0);
    check_eq("over_idle_req", 32'(step_req), 0);
    enter     = 1'b0;
    game_over = 1'b1;
    tick();
    check_eq("idle_ignores_go", 32'(state), 0);
    game_over = 1'b0;
    tick();

    // Reset mid-count with left held
    auto_ack = 1'b1;
    enter = 1'b1;
    tick();
    check_eq("rerun_state", 32'(state), 1);
    enter = 1'b0;
    left  = 1'b1;
    tick();
    check_eq("rerun_left_req", 32'(step_req), 1);
    check_eq("rerun_left_dir", 32'(step_dir), 2);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("mid_rst_dir", 32'(dir), 0);
    check_eq("mid_rst_valid", 32'(dir_valid), 0);
    check_eq("mid_rst_req", 32'(step_req), 0);
    check_eq("mid_rst_step_dir", 32'(step_dir), 0);
    check_eq("mid_rst_miss", 32'(step_miss), 0);
    check_eq("mid_rst_state", 32'(state), 0);
    check_eq("mid_rst_start", 32'(start_pulse), 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_dir", 32'(dir), 2);
    check_eq("post_rst_valid", 32'(dir_valid), 1);
    check_eq("post_rst_state", 32'(state), 0);
    check_eq("post_rst_req", 32'(step_req), 0);
    left = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
